// File: rtl/cnn_layer_accel_awe_weight_buffer_if.sv
// Load / swap / read bundle for the AWE double-buffered weight buffer.
// master: the side that streams weights and issues reads.
// slave:  the weight buffer itself.
interface cnn_layer_accel_awe_weight_buffer_if #(
    parameter int WIDTH     = 16,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 8
);
    logic                       ld_start;
    logic [ADDR_W:0]            ld_len;
    logic                       ld_valid;
    logic [WIDTH-1:0]           ld_data;
    logic                       ld_ready;
    logic                       ld_done;
    logic                       swap;
    logic                       swap_err;
    logic                       active_sel;
    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr;
    logic [NUM_BANKS*WIDTH-1:0] rd_data;
    logic                       rd_valid;
    logic                       rd_parity_err;

    modport master (
        output ld_start, ld_len, ld_valid, ld_data, swap, rd_en, rd_addr,
        input  ld_ready, ld_done, swap_err, active_sel, rd_data, rd_valid, rd_parity_err
    );

    modport slave (
        input  ld_start, ld_len, ld_valid, ld_data, swap, rd_en, rd_addr,
        output ld_ready, ld_done, swap_err, active_sel, rd_data, rd_valid, rd_parity_err
    );
endinterface

// File: rtl/cnn_layer_accel_awe_weight_buffer.sv
// Double-buffered multi-bank weight store. Each bank holds two halves; reads
// use the active half while the loader fills the shadow half, and a swap
// exchanges them. Read latency is two edges after the request is sampled.
// Optional macro AWE_WT_PARITY_EN stores an even-parity bit per word and
// flags parity errors on read.
module cnn_layer_accel_awe_weight_buffer #(
    parameter int WIDTH     = 16,
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    cnn_layer_accel_awe_weight_buffer_if.slave bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
`ifdef AWE_WT_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef AWE_WT_PARITY_EN
    // Even parity: stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // A stored word (data plus parity) with odd weight is corrupt.
    function automatic logic parity_bad(input logic [MEM_W-1:0] w);
        return ^w;
    endfunction
`endif

    state_t              r_state, w_state_nxt;
    logic                r_active_sel, w_active_sel_nxt;
    logic [ADDR_W:0]     r_len, w_len_nxt, w_len_clamped;
    logic [BANK_W-1:0]   r_bank;
    logic [ADDR_W-1:0]   r_waddr;
    logic                r_ld_ready, r_ld_done, r_swap_err;
    logic                w_accept, w_last_beat;
    logic [MEM_W-1:0]    w_wr_word;

    logic [MEM_W-1:0]    r_mem [NUM_BANKS][2*DEPTH];

    logic                r_req_v;
    logic [ADDR_W:0]     r_req_addr;
    logic                r_ram_v;
    logic [MEM_W-1:0]    r_ram_q [NUM_BANKS];
    logic [NUM_BANKS*WIDTH-1:0] w_rd_word;
    logic [NUM_BANKS*WIDTH-1:0] r_rd_data;
    logic                r_rd_valid;

    // A zero-length load accepts nothing; it only passes through LOAD once.
    assign w_accept    = r_ld_ready && bus.ld_valid && (r_len != '0);
    assign w_last_beat = ({1'b0, r_waddr} == (r_len - 1'b1)) && (r_bank == LAST_BANK);

`ifdef AWE_WT_PARITY_EN
    assign w_wr_word = {even_parity(bus.ld_data), bus.ld_data};
`else
    assign w_wr_word = bus.ld_data;
`endif

    // Loader next-state, swap handling and length clamp.
    always_comb begin
        w_state_nxt      = r_state;
        w_active_sel_nxt = r_active_sel;
        w_len_nxt        = r_len;
        if (bus.ld_len > DEPTH_L) begin
            w_len_clamped = DEPTH_L;
        end else begin
            w_len_clamped = bus.ld_len;
        end
        case (r_state)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_len_nxt   = w_len_clamped;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_len == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (w_accept && w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (bus.swap) begin
                    w_active_sel_nxt = ~r_active_sel;
                    if (bus.ld_start) begin
                        w_state_nxt = ST_LOAD;
                        w_len_nxt   = w_len_clamped;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (bus.ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_len_nxt   = w_len_clamped;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loader state, half select, registered status outputs and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_active_sel <= 1'b0;
            r_len        <= '0;
            r_ld_ready   <= 1'b0;
            r_ld_done    <= 1'b0;
            r_swap_err   <= 1'b0;
            r_bank       <= '0;
            r_waddr      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_sel <= w_active_sel_nxt;
            r_len        <= w_len_nxt;
            r_ld_ready   <= (w_state_nxt == ST_LOAD);
            r_ld_done    <= (w_state_nxt == ST_DONE);
            r_swap_err   <= bus.swap && (r_state != ST_DONE);
            if ((w_state_nxt == ST_LOAD) && (r_state != ST_LOAD)) begin
                r_bank  <= '0;
                r_waddr <= '0;
            end else if (w_accept) begin
                if (r_bank == LAST_BANK) begin
                    r_bank  <= '0;
                    r_waddr <= r_waddr + 1'b1;
                end else begin
                    r_bank  <= r_bank + 1'b1;
                end
            end
        end
    end

    // Shadow-half write port; storage is block RAM and is never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_bank == BANK_W'(b)) begin
                    r_mem[b][{~r_active_sel, r_waddr}] <= w_wr_word;
                end
            end
        end
    end

    // Read request register: the half select travels with the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_v    <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_req_v <= bus.rd_en;
            if (bus.rd_en) begin
                r_req_addr <= {r_active_sel, bus.rd_addr};
            end
        end
    end

    // RAM output register for every bank.
    always_ff @(posedge clk) begin
        if (r_req_v) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_ram_q[b] <= r_mem[b][r_req_addr];
            end
        end
    end

    // Valid bit alongside the RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_v <= 1'b0;
        end else begin
            r_ram_v <= r_req_v;
        end
    end

    // Gather per-bank words into the output bus.
    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rd_word[b*WIDTH +: WIDTH] = r_ram_q[b][WIDTH-1:0];
        end
    end

    // Output register; data holds when no read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= r_ram_v;
            if (r_ram_v) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

`ifdef AWE_WT_PARITY_EN
    logic w_perr;
    logic r_rd_perr;

    // OR of per-bank parity checks on the RAM output register.
    always_comb begin
        w_perr = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_perr = w_perr | parity_bad(r_ram_q[b]);
        end
    end

    // Parity flag registered with the same timing as rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_perr <= 1'b0;
        end else if (r_ram_v) begin
            r_rd_perr <= w_perr;
        end else begin
            r_rd_perr <= r_rd_perr;
        end
    end

    assign bus.rd_parity_err = r_rd_perr;
`else
    assign bus.rd_parity_err = 1'b0;
`endif

    assign bus.ld_ready   = r_ld_ready;
    assign bus.ld_done    = r_ld_done;
    assign bus.swap_err   = r_swap_err;
    assign bus.active_sel = r_active_sel;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
endmodule

// File: tb/tb_cnn_layer_accel_awe_weight_buffer.sv
// Directed bench for the AWE double-buffered weight buffer. A small model of
// both halves of every bank tracks which words the loader should have
// written; each read is checked two edges after it is sampled.
module tb_cnn_layer_accel_awe_weight_buffer;
    localparam int WIDTH = 16;
    localparam int NB    = 4;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_layer_accel_awe_weight_buffer_if #(.WIDTH(WIDTH), .NUM_BANKS(NB), .ADDR_W(AW)) bus();

    cnn_layer_accel_awe_weight_buffer #(
        .WIDTH(WIDTH), .NUM_BANKS(NB), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [15:0] m [0:3][0:511];
    logic        exp_sel;
    logic        g_rd_en;
    logic [7:0]  g_rd_addr;
    int          g_rd_lim;
    int          g_bad_addr;
    logic        ev_v [2];
    logic [63:0] ev_d [2];
    logic        ev_p [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic sel, input logic [7:0] a);
        return {m[3][{sel, a}], m[2][{sel, a}], m[1][{sel, a}], m[0][{sel, a}]};
    endfunction

    // One clock: issue the current read (if any), then check the read issued two calls ago.
    task automatic step();
        logic [63:0] e;
        logic        ep;
        bus.rd_en   = g_rd_en;
        bus.rd_addr = g_rd_addr;
        e  = model_word(exp_sel, g_rd_addr);
        ep = (exp_sel == 1'b0) && (int'(g_rd_addr) == g_bad_addr);
        @(posedge clk); #1;
        if (ev_v[1]) begin
            check("rd_valid", 64'(bus.rd_valid), 64'd1);
            check("rd_data", bus.rd_data, ev_d[1]);
            check("rd_parity_err", 64'(bus.rd_parity_err), 64'(ev_p[1]));
        end else begin
            check("rd_valid_idle", 64'(bus.rd_valid), 64'd0);
        end
        ev_v[1] = ev_v[0]; ev_d[1] = ev_d[0]; ev_p[1] = ev_p[0];
        ev_v[0] = g_rd_en; ev_d[0] = e;       ev_p[0] = ep;
        if (g_rd_en) g_rd_addr = 8'((int'(g_rd_addr) + 1) % g_rd_lim);
        bus.rd_en = 1'b0;
    endtask

    task automatic start_load(input logic [8:0] len);
        bus.ld_start = 1'b1;
        bus.ld_len   = len;
        step();
        bus.ld_start = 1'b0;
    endtask

    task automatic stream_beats(input logic [15:0] base, input int n_exp, input bit rnd, input bit expect_done);
        int   k = 0;
        int   cyc = 0;
        logic acc;
        if (n_exp > 0) begin
            check("ld_ready_start", 64'(bus.ld_ready), 64'd1);
            check("ld_done_start", 64'(bus.ld_done), 64'd0);
        end
        while (k < n_exp && cyc < 6000) begin
            bus.ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ld_data  = base + 16'(k);
            acc = bus.ld_valid && bus.ld_ready;
            if (acc) m[k % 4][{~exp_sel, 8'(k / 4)}] = bus.ld_data;
            step();
            cyc++;
            if (acc) k++;
        end
        bus.ld_valid = 1'b0;
        check("ld_beats", 64'(k), 64'(n_exp));
        if (expect_done) begin
            check("ld_done_rise", 64'(bus.ld_done), 64'd1);
            check("ld_ready_fall", 64'(bus.ld_ready), 64'd0);
        end
    endtask

    task automatic do_swap(input bit ok);
        bus.swap = 1'b1;
        step();
        bus.swap = 1'b0;
        if (ok) exp_sel = ~exp_sel;
        check("active_sel", 64'(bus.active_sel), 64'(exp_sel));
        check("swap_err", 64'(bus.swap_err), 64'(!ok));
    endtask

    task automatic read_run(input logic [7:0] start, input int n, input int lim);
        g_rd_en = 1'b1; g_rd_addr = start; g_rd_lim = lim;
        repeat (n) step();
        g_rd_en = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_active_sel"}, 64'(bus.active_sel), 64'd0);
        check({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'd0);
        check({tag, "_ld_done"}, 64'(bus.ld_done), 64'd0);
        check({tag, "_swap_err"}, 64'(bus.swap_err), 64'd0);
        check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        check({tag, "_rd_data"}, bus.rd_data, 64'd0);
        check({tag, "_rd_parity_err"}, 64'(bus.rd_parity_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_start = 1'b0; bus.ld_len = 9'd0; bus.ld_valid = 1'b0; bus.ld_data = 16'd0;
        bus.swap = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = 8'd0;
        g_rd_en = 1'b0; g_rd_addr = 8'd0; g_rd_lim = 4; g_bad_addr = -1;
        ev_v[0] = 1'b0; ev_v[1] = 1'b0; ev_d[0] = 64'd0; ev_d[1] = 64'd0;
        ev_p[0] = 1'b0; ev_p[1] = 1'b0;
        exp_sel = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // swap in IDLE, then swap during LOAD: both rejected
        do_swap(1'b0);
        step();
        check("swap_err_pulse_idle", 64'(bus.swap_err), 64'd0);
        start_load(9'd4);
        do_swap(1'b0);
        step();
        check("swap_err_pulse_load", 64'(bus.swap_err), 64'd0);
        stream_beats(16'h0000, 16, 1'b0, 1'b1);

        // Basic readback of half 1 after a good swap
        do_swap(1'b1);
        g_rd_en = 1'b1; g_rd_addr = 8'd0; g_rd_lim = 4;
        step(); step(); step();
        check("rd_addr0_const", bus.rd_data, 64'h0003_0002_0001_0000);
        step();
        check("rd_addr1_const", bus.rd_data, 64'h0007_0006_0005_0004);
        g_rd_en = 1'b0;
        repeat (3) step();

        // Ping-pong: fill half 0, swap, then load half 1 under continuous reads
        start_load(9'd4);
        stream_beats(16'h0200, 16, 1'b0, 1'b1);
        do_swap(1'b1);
        g_rd_en = 1'b1; g_rd_addr = 8'd0; g_rd_lim = 4;
        start_load(9'd4);
        stream_beats(16'h0100, 16, 1'b0, 1'b1);
        step();
        do_swap(1'b1);
        repeat (6) step();
        g_rd_en = 1'b0;
        repeat (3) step();

        // Full-depth load with random ld_valid bubbles
        start_load(9'd256);
        stream_beats(16'h4000, DEPTH * NB, 1'b1, 1'b1);
        bus.ld_valid = 1'b1; bus.ld_data = 16'hBEEF;
        step();
        check("full_no_extra_ready", 64'(bus.ld_ready), 64'd0);
        check("full_done_hold", 64'(bus.ld_done), 64'd1);
        bus.ld_valid = 1'b0;
        do_swap(1'b1);
        read_run(8'd0, DEPTH, DEPTH);

        // ld_len = 0: DONE on the next cycle, no write even with ld_valid high
        bus.ld_start = 1'b1; bus.ld_len = 9'd0;
        bus.ld_valid = 1'b1; bus.ld_data = 16'hDEAD;
        step();
        bus.ld_start = 1'b0;
        check("len0_done_low", 64'(bus.ld_done), 64'd0);
        step();
        bus.ld_valid = 1'b0;
        check("len0_done_high", 64'(bus.ld_done), 64'd1);
        check("len0_ready_low", 64'(bus.ld_ready), 64'd0);
        do_swap(1'b1);
        read_run(8'd0, 4, 4);

        // ld_len = DEPTH+5 clamps to DEPTH
        start_load(9'd261);
        stream_beats(16'h8000, DEPTH * NB, 1'b0, 1'b1);
        bus.ld_valid = 1'b1; bus.ld_data = 16'hFACE;
        step();
        check("clamp_no_extra_ready", 64'(bus.ld_ready), 64'd0);
        bus.ld_valid = 1'b0;

        // swap and ld_start together in DONE
        bus.swap = 1'b1; bus.ld_start = 1'b1; bus.ld_len = 9'd2;
        step();
        bus.swap = 1'b0; bus.ld_start = 1'b0;
        exp_sel = ~exp_sel;
        check("swapld_active_sel", 64'(bus.active_sel), 64'(exp_sel));
        check("swapld_swap_err", 64'(bus.swap_err), 64'd0);
        stream_beats(16'hA000, 8, 1'b0, 1'b1);
        do_swap(1'b1);
        read_run(8'd0, 4, 4);

        // Reset in the middle of a load with reads in flight
        start_load(9'd4);
        stream_beats(16'hC000, 5, 1'b0, 1'b0);
        check("midload_ready", 64'(bus.ld_ready), 64'd1);
        g_rd_en = 1'b1; g_rd_addr = 8'd0; g_rd_lim = 4;
        step(); step();
        g_rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ev_v[0] = 1'b0; ev_v[1] = 1'b0;
        exp_sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step();
        check_reset_outputs("postrst");
        read_run(8'd0, 4, 4);

`ifdef AWE_WT_PARITY_EN
        // Corrupt one stored bit in bank 2, half 0, address 3
        m[2][9'd3] = m[2][9'd3] ^ 16'h0001;
        dut.r_mem[2][9'd3] = dut.r_mem[2][9'd3] ^ 17'h00001;
        g_bad_addr = 3;
        read_run(8'd2, 3, 4);
        g_bad_addr = -1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
